// File: rtl/reorder_buffer_pkg.sv
// rtl/reorder_buffer_pkg.sv - shared sizes, entry layout and pointer helpers for the reorder buffer
package reorder_buffer_pkg;

  localparam int ROB_ADDR_W = 5;
  localparam int ROB_DEPTH  = 1 << ROB_ADDR_W;
  localparam int PR_ADDR_W  = 5;
  localparam int PHYS_W     = 2 * PR_ADDR_W;

  typedef logic [ROB_ADDR_W-1:0] rob_idx_t;
  typedef logic [ROB_ADDR_W:0]   rob_ptr_t;

  // One ROB entry; arch/phys/old_phys are {val,flags} pairs
  typedef struct packed {
    logic              valid;
    logic              done;
    logic              is_term;
    logic [7:0]        arch;
    logic [PHYS_W-1:0] phys;
    logic [PHYS_W-1:0] old_phys;
  } rob_entry_t;

  // Full when the index bits match but the wrap bits differ
  function automatic logic ptr_full(input rob_ptr_t head, input rob_ptr_t tail);
    return (head[ROB_ADDR_W-1:0] == tail[ROB_ADDR_W-1:0]) &&
           (head[ROB_ADDR_W] != tail[ROB_ADDR_W]);
  endfunction

endpackage

// File: rtl/reorder_buffer_entry_store.sv
// rtl/reorder_buffer_entry_store.sv - ROB entry array with alloc, three completion and one head read port
module rob_entry_store
  import reorder_buffer_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 alloc_en,
  input  rob_idx_t             alloc_idx,
  input  logic [PHYS_W-1:0]    alloc_old_phys,
  input  logic                 alloc_is_term,
  input  logic                 clear_en,
  input  rob_idx_t             clear_idx,
  input  logic                 arith_en,
  input  rob_idx_t             arith_idx,
  input  logic [7:0]           arith_arch,
  input  logic [PHYS_W-1:0]    arith_phys,
  input  logic                 mem_en,
  input  rob_idx_t             mem_idx,
  input  logic [3:0]           mem_arch,
  input  logic [PR_ADDR_W-1:0] mem_phys,
  input  logic                 term_en,
  input  rob_idx_t             term_idx,
  input  logic [7:0]           term_arch,
  input  logic [PHYS_W-1:0]    term_phys,
  input  rob_idx_t             head_idx,
  output rob_entry_t           head_entry,
  output logic [ROB_DEPTH-1:0] valid_bits
);

  rob_entry_t entries [ROB_DEPTH];

  // Per-entry update: flush wins, then retire-clear, alloc, and completions to live entries
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ROB_DEPTH; i++) entries[i] <= '0;
    end else begin
      for (int i = 0; i < ROB_DEPTH; i++) begin
        if (flush) begin
          entries[i].valid <= 1'b0;
          entries[i].done  <= 1'b0;
        end else begin
          if (clear_en && clear_idx == rob_idx_t'(i)) begin
            entries[i].valid <= 1'b0;
            entries[i].done  <= 1'b0;
          end
          if (alloc_en && alloc_idx == rob_idx_t'(i)) begin
            entries[i].valid    <= 1'b1;
            entries[i].done     <= 1'b0;
            entries[i].is_term  <= alloc_is_term;
            entries[i].old_phys <= alloc_old_phys;
            entries[i].arch     <= '0;
            entries[i].phys     <= '0;
          end
          if (entries[i].valid) begin
            if (arith_en && arith_idx == rob_idx_t'(i)) begin
              entries[i].done <= 1'b1;
              entries[i].arch <= arith_arch;
              entries[i].phys <= arith_phys;
            end
            // Mem ops write only the val slot; flags slot carries "no mapping"
            if (mem_en && mem_idx == rob_idx_t'(i)) begin
              entries[i].done <= 1'b1;
              entries[i].arch <= {mem_arch, 4'h0};
              entries[i].phys <= {mem_phys, {PR_ADDR_W{1'b0}}};
            end
            if (term_en && term_idx == rob_idx_t'(i)) begin
              entries[i].done <= 1'b1;
              entries[i].arch <= term_arch;
              entries[i].phys <= term_phys;
            end
          end
        end
      end
    end
  end

  // Head read port and live-entry vector
  always_comb begin
    head_entry = entries[head_idx];
    for (int i = 0; i < ROB_DEPTH; i++) valid_bits[i] = entries[i].valid;
  end

endmodule

// File: rtl/reorder_buffer.sv
// rtl/reorder_buffer.sv - in-order retirement with out-of-order completion and term-op redirect
module reorder_buffer
  import reorder_buffer_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   alloc_valid,
  output logic                   alloc_ready,
  input  logic [2*PR_ADDR_W-1:0] alloc_old_phys,
  input  logic                   alloc_is_term,
  output logic [ROB_ADDR_W-1:0]  alloc_entry,
  input  logic                   arith_cpl_valid,
  input  logic [ROB_ADDR_W-1:0]  arith_cpl_entry,
  input  logic [7:0]             arith_cpl_arch,
  input  logic [2*PR_ADDR_W-1:0] arith_cpl_phys,
  input  logic                   mem_cpl_valid,
  input  logic [ROB_ADDR_W-1:0]  mem_cpl_entry,
  input  logic [3:0]             mem_cpl_arch,
  input  logic [PR_ADDR_W-1:0]   mem_cpl_phys,
  input  logic                   term_cpl_valid,
  output logic                   term_cpl_ready,
  input  logic [ROB_ADDR_W-1:0]  term_cpl_entry,
  input  logic [7:0]             term_cpl_arch,
  input  logic [2*PR_ADDR_W-1:0] term_cpl_phys,
  input  logic [15:0]            term_cpl_target,
  output logic                   commit_valid,
  output logic [7:0]             commit_arch,
  output logic [2*PR_ADDR_W-1:0] commit_phys,
  output logic [2*PR_ADDR_W-1:0] commit_free,
  output logic                   redirect_valid,
  output logic [15:0]            redirect_target
);

  rob_ptr_t             head;
  rob_ptr_t             tail;
  logic                 target_held;
  logic [15:0]          target;
  rob_entry_t           head_entry;
  logic [ROB_DEPTH-1:0] valid_bits;
  logic                 alloc_fire;
  logic                 term_fire;

  // Handshakes, commit view of the head entry and the redirect pulse
  always_comb begin
    commit_valid    = head_entry.valid & head_entry.done;
    redirect_valid  = commit_valid & head_entry.is_term;
    alloc_ready     = !ptr_full(head, tail) && !redirect_valid;
    alloc_fire      = alloc_valid & alloc_ready;
    term_cpl_ready  = !target_held;
    term_fire       = term_cpl_valid & term_cpl_ready;
    alloc_entry     = tail[ROB_ADDR_W-1:0];
    commit_arch     = commit_valid ? head_entry.arch : '0;
    commit_phys     = commit_valid ? head_entry.phys : '0;
    commit_free     = commit_valid ? head_entry.old_phys : '0;
    redirect_target = redirect_valid ? target : '0;
  end

  // Pointers: a term commit empties the buffer just past the retiring entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
    end else if (redirect_valid) begin
      head <= head + rob_ptr_t'(1);
      tail <= head + rob_ptr_t'(1);
    end else begin
      if (commit_valid) head <= head + rob_ptr_t'(1);
      if (alloc_fire)   tail <= tail + rob_ptr_t'(1);
    end
  end

  // Single resolved-target register; only a completion to a live entry claims it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      target_held <= 1'b0;
      target      <= '0;
    end else if (redirect_valid) begin
      target_held <= 1'b0;
    end else if (term_fire && valid_bits[term_cpl_entry]) begin
      target_held <= 1'b1;
      target      <= term_cpl_target;
    end
  end

  rob_entry_store u_store (
    .clk            (clk),
    .rst            (rst),
    .flush          (redirect_valid),
    .alloc_en       (alloc_fire),
    .alloc_idx      (tail[ROB_ADDR_W-1:0]),
    .alloc_old_phys (alloc_old_phys),
    .alloc_is_term  (alloc_is_term),
    .clear_en       (commit_valid),
    .clear_idx      (head[ROB_ADDR_W-1:0]),
    .arith_en       (arith_cpl_valid),
    .arith_idx      (arith_cpl_entry),
    .arith_arch     (arith_cpl_arch),
    .arith_phys     (arith_cpl_phys),
    .mem_en         (mem_cpl_valid),
    .mem_idx        (mem_cpl_entry),
    .mem_arch       (mem_cpl_arch),
    .mem_phys       (mem_cpl_phys),
    .term_en        (term_fire),
    .term_idx       (term_cpl_entry),
    .term_arch      (term_cpl_arch),
    .term_phys      (term_cpl_phys),
    .head_idx       (head[ROB_ADDR_W-1:0]),
    .head_entry     (head_entry),
    .valid_bits     (valid_bits)
  );

endmodule

// File: tb/tb_reorder_buffer.sv
// tb/tb_reorder_buffer.sv - directed table-driven bench for reorder_buffer
module tb_reorder_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        alloc_valid;
  logic        alloc_ready;
  logic [9:0]  alloc_old_phys;
  logic        alloc_is_term;
  logic [4:0]  alloc_entry;
  logic        arith_cpl_valid;
  logic [4:0]  arith_cpl_entry;
  logic [7:0]  arith_cpl_arch;
  logic [9:0]  arith_cpl_phys;
  logic        mem_cpl_valid;
  logic [4:0]  mem_cpl_entry;
  logic [3:0]  mem_cpl_arch;
  logic [4:0]  mem_cpl_phys;
  logic        term_cpl_valid;
  logic        term_cpl_ready;
  logic [4:0]  term_cpl_entry;
  logic [7:0]  term_cpl_arch;
  logic [9:0]  term_cpl_phys;
  logic [15:0] term_cpl_target;
  logic        commit_valid;
  logic [7:0]  commit_arch;
  logic [9:0]  commit_phys;
  logic [9:0]  commit_free;
  logic        redirect_valid;
  logic [15:0] redirect_target;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  reorder_buffer dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_old_phys(alloc_old_phys),
    .alloc_is_term(alloc_is_term), .alloc_entry(alloc_entry),
    .arith_cpl_valid(arith_cpl_valid), .arith_cpl_entry(arith_cpl_entry),
    .arith_cpl_arch(arith_cpl_arch), .arith_cpl_phys(arith_cpl_phys),
    .mem_cpl_valid(mem_cpl_valid), .mem_cpl_entry(mem_cpl_entry),
    .mem_cpl_arch(mem_cpl_arch), .mem_cpl_phys(mem_cpl_phys),
    .term_cpl_valid(term_cpl_valid), .term_cpl_ready(term_cpl_ready),
    .term_cpl_entry(term_cpl_entry), .term_cpl_arch(term_cpl_arch),
    .term_cpl_phys(term_cpl_phys), .term_cpl_target(term_cpl_target),
    .commit_valid(commit_valid), .commit_arch(commit_arch), .commit_phys(commit_phys),
    .commit_free(commit_free), .redirect_valid(redirect_valid), .redirect_target(redirect_target)
  );

  typedef struct {
    logic       av;    logic [9:0] aold; logic       aterm;
    logic       xv;    logic [4:0] xe;   logic [7:0] xarch; logic [9:0] xphys;
    logic       mv;    logic [4:0] me;   logic [3:0] march; logic [4:0] mphys;
    logic       ar;    logic [4:0] ae;   logic       cv;
    logic [7:0] ca;    logic [9:0] cp;   logic [9:0] cf;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alloc_valid = 0; alloc_old_phys = '0; alloc_is_term = 0;
    arith_cpl_valid = 0; arith_cpl_entry = '0; arith_cpl_arch = '0; arith_cpl_phys = '0;
    mem_cpl_valid = 0; mem_cpl_entry = '0; mem_cpl_arch = '0; mem_cpl_phys = '0;
    term_cpl_valid = 0; term_cpl_entry = '0; term_cpl_arch = '0; term_cpl_phys = '0;
    term_cpl_target = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // av aold aterm | xv xe xarch xphys | mv me march mphys | ar ae cv ca cp cf
    vecs[0] = '{1, 10'h043, 0, 0, 0, 8'h00, 10'h000, 0, 0, 4'h0, 5'd0,  1, 0, 0, 8'h00, 10'h000, 10'h000};
    vecs[1] = '{1, 10'h000, 0, 0, 0, 8'h00, 10'h000, 0, 0, 4'h0, 5'd0,  1, 1, 0, 8'h00, 10'h000, 10'h000};
    vecs[2] = '{1, 10'h085, 0, 0, 0, 8'h00, 10'h000, 0, 0, 4'h0, 5'd0,  1, 2, 0, 8'h00, 10'h000, 10'h000};
    vecs[3] = '{0, 10'h000, 0, 1, 2, 8'h21, 10'h0E8, 0, 0, 4'h0, 5'd0,  1, 3, 0, 8'h00, 10'h000, 10'h000};
    vecs[4] = '{0, 10'h000, 0, 1, 0, 8'h1F, 10'h12A, 0, 0, 4'h0, 5'd0,  1, 3, 0, 8'h00, 10'h000, 10'h000};
    vecs[5] = '{0, 10'h000, 0, 0, 0, 8'h00, 10'h000, 1, 1, 4'h3, 5'd12, 1, 3, 1, 8'h1F, 10'h12A, 10'h043};
    vecs[6] = '{1, 10'h000, 0, 0, 0, 8'h00, 10'h000, 0, 0, 4'h0, 5'd0,  1, 3, 1, 8'h30, 10'h180, 10'h000};
    vecs[7] = '{0, 10'h000, 0, 0, 0, 8'h00, 10'h000, 0, 0, 4'h0, 5'd0,  1, 4, 1, 8'h21, 10'h0E8, 10'h085};
    vecs[8] = '{0, 10'h000, 0, 1, 3, 8'hA5, 10'h3FF, 0, 0, 4'h0, 5'd0,  1, 4, 0, 8'h00, 10'h000, 10'h000};

    idle_inputs();
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    #1;
    chk("rst_alloc_ready", alloc_ready, 1);
    chk("rst_term_ready", term_cpl_ready, 1);
    chk("rst_commit_valid", commit_valid, 0);
    chk("rst_redirect", redirect_valid, 0);
    chk("rst_alloc_entry", alloc_entry, 0);
    tick();

    // In-order retirement of out-of-order completions, plus alloc alongside commit
    for (int i = 0; i < 9; i++) begin
      alloc_valid = vecs[i].av; alloc_old_phys = vecs[i].aold; alloc_is_term = vecs[i].aterm;
      arith_cpl_valid = vecs[i].xv; arith_cpl_entry = vecs[i].xe;
      arith_cpl_arch = vecs[i].xarch; arith_cpl_phys = vecs[i].xphys;
      mem_cpl_valid = vecs[i].mv; mem_cpl_entry = vecs[i].me;
      mem_cpl_arch = vecs[i].march; mem_cpl_phys = vecs[i].mphys;
      #1;
      chk($sformatf("v%0d_alloc_ready", i), alloc_ready, vecs[i].ar);
      chk($sformatf("v%0d_alloc_entry", i), alloc_entry, vecs[i].ae);
      chk($sformatf("v%0d_commit_valid", i), commit_valid, vecs[i].cv);
      chk($sformatf("v%0d_commit_arch", i), commit_arch, vecs[i].ca);
      chk($sformatf("v%0d_commit_phys", i), commit_phys, vecs[i].cp);
      chk($sformatf("v%0d_commit_free", i), commit_free, vecs[i].cf);
      chk($sformatf("v%0d_redirect", i), redirect_valid, 0);
      tick();
    end
    idle_inputs();
    #1;
    chk("pre_rst_commit_valid", commit_valid, 1);
    chk("pre_rst_commit_arch", commit_arch, 8'hA5);

    // Asynchronous reset mid-cycle, no clock edge
    #3 rst = 1;
    #1;
    chk("async_rst_alloc_ready", alloc_ready, 1);
    chk("async_rst_commit_valid", commit_valid, 0);
    chk("async_rst_redirect", redirect_valid, 0);
    chk("async_rst_alloc_entry", alloc_entry, 0);
    #2 rst = 0;
    tick();

    // Fill all 32 entries, then free one and wrap
    for (int i = 0; i < 32; i++) begin
      alloc_valid = 1;
      alloc_old_phys = (i == 4) ? 10'h043 : 10'h000;
      #1;
      chk($sformatf("fill%0d_ready", i), alloc_ready, 1);
      chk($sformatf("fill%0d_entry", i), alloc_entry, i[4:0]);
      tick();
    end
    alloc_valid = 0; alloc_old_phys = '0;
    arith_cpl_valid = 1; arith_cpl_entry = 0;
    #1;
    chk("full_ready", alloc_ready, 0);
    tick();
    arith_cpl_valid = 0;
    #1;
    chk("full_commit0_valid", commit_valid, 1);
    chk("full_commit0_ready", alloc_ready, 0);
    tick();
    chk("after_commit0_ready", alloc_ready, 1);
    chk("wrap_alloc_entry", alloc_entry, 0);
    alloc_valid = 1;
    tick();
    alloc_valid = 0;
    #1;
    chk("refull_ready", alloc_ready, 0);

    // Completions of 1..4 and a field check on entry 4
    arith_cpl_valid = 1; arith_cpl_entry = 1; arith_cpl_arch = 8'h00; arith_cpl_phys = '0;
    mem_cpl_valid = 1; mem_cpl_entry = 2; mem_cpl_arch = 4'h5; mem_cpl_phys = 5'd6;
    tick();
    mem_cpl_valid = 0;
    arith_cpl_entry = 3;
    #1;
    chk("c1_valid", commit_valid, 1);
    chk("c1_arch", commit_arch, 8'h00);
    tick();
    arith_cpl_entry = 4; arith_cpl_arch = 8'h1F; arith_cpl_phys = 10'h12A;
    #1;
    chk("c2_valid", commit_valid, 1);
    chk("c2_arch", commit_arch, 8'h50);
    chk("c2_phys", commit_phys, 10'h0C0);
    tick();
    idle_inputs();
    #1;
    chk("c3_valid", commit_valid, 1);
    tick();
    chk("c4_valid", commit_valid, 1);
    chk("c4_arch", commit_arch, 8'h1F);
    chk("c4_phys", commit_phys, 10'h12A);
    chk("c4_free", commit_free, 10'h043);
    tick();
    chk("c5_none", commit_valid, 0);

    // Term redirect and flush; second term blocked while target held
    rst = 1;
    tick();
    rst = 0;
    for (int i = 0; i < 4; i++) begin
      alloc_valid = 1; alloc_is_term = (i == 1);
      tick();
    end
    idle_inputs();
    arith_cpl_valid = 1; arith_cpl_entry = 2;
    mem_cpl_valid = 1; mem_cpl_entry = 3; mem_cpl_arch = 4'h2; mem_cpl_phys = 5'd4;
    term_cpl_valid = 1; term_cpl_entry = 1; term_cpl_target = 16'hC000;
    #1;
    chk("t1_ready", term_cpl_ready, 1);
    tick();
    mem_cpl_valid = 0;
    arith_cpl_entry = 0;
    term_cpl_entry = 3; term_cpl_target = 16'hBEEF;
    #1;
    chk("t2_blocked", term_cpl_ready, 0);
    tick();
    arith_cpl_valid = 0;
    #1;
    chk("t2_still_blocked", term_cpl_ready, 0);
    chk("t_commit0_valid", commit_valid, 1);
    chk("t_commit0_redirect", redirect_valid, 0);
    tick();
    term_cpl_valid = 0;
    alloc_valid = 1;
    #1;
    chk("redir_valid", redirect_valid, 1);
    chk("redir_target", redirect_target, 16'hC000);
    chk("redir_commit_valid", commit_valid, 1);
    chk("redir_alloc_ready", alloc_ready, 0);
    tick();
    alloc_valid = 0;
    #1;
    chk("post_redir_pulse", redirect_valid, 0);
    chk("post_redir_commit", commit_valid, 0);
    chk("post_redir_term_ready", term_cpl_ready, 1);
    chk("post_redir_alloc_ready", alloc_ready, 1);
    chk("post_redir_alloc_entry", alloc_entry, 2);
    tick();
    chk("flushed_no_commit", commit_valid, 0);
    alloc_valid = 1; alloc_is_term = 1;
    tick();
    idle_inputs();
    term_cpl_valid = 1; term_cpl_entry = 2; term_cpl_target = 16'hBEEF;
    #1;
    chk("t3_ready", term_cpl_ready, 1);
    tick();
    term_cpl_valid = 0;
    #1;
    chk("t3_held", term_cpl_ready, 0);
    chk("t3_redirect", redirect_valid, 1);
    chk("t3_target", redirect_target, 16'hBEEF);
    tick();
    chk("t3_pulse_end", redirect_valid, 0);
    chk("t3_ready_again", term_cpl_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
